// File: rtl/window_streamer.sv
// -----------------------------------------------------------------------------
// window_streamer
//
// Streams every WIN x WIN pixel window of a REG_W x REG_H 8-bit search region
// out of word-organised frame memory. A WIN-row line buffer is filled from
// memory, windows are emitted from it row by row (x ascending), and between
// window rows the buffer is shifted up by STRIDE rows and topped up with the
// next STRIDE region rows.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              begin a sweep (only looked at while idle)
//   busy, done         sweep in progress / one-cycle completion pulse
//   rd_en, rd_row,     memory read request: region row and word index in row
//   rd_col
//   rd_data            read data, one cycle after rd_en; [7:0] = leftmost pixel
//   win_valid,         window output handshake
//   win_ready
//   win_data           pixel (r,c) at bits [(r*WIN+c)*8 +: 8]
//   win_x, win_y       top-left coordinate of the presented window
// -----------------------------------------------------------------------------
module window_streamer #(
    parameter int WIN    = 16,
    parameter int REG_W  = 80,
    parameter int REG_H  = 80,
    parameter int BPW    = 4,
    parameter int STRIDE = 1,
    localparam int WPR   = REG_W / BPW,
    localparam int CW    = $clog2((REG_W > REG_H) ? REG_W : REG_H),
    localparam int CLW   = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [CW-1:0]           rd_row,
    output logic [CLW-1:0]          rd_col,
    input  logic [8*BPW-1:0]        rd_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [WIN*WIN*8-1:0]    win_data,
    output logic [CW-1:0]           win_x,
    output logic [CW-1:0]           win_y
);

    if ((REG_W % BPW) != 0 || WIN > REG_W || WIN > REG_H || STRIDE < 1 ||
        STRIDE > WIN || ((REG_W - WIN) % STRIDE) != 0 ||
        ((REG_H - WIN) % STRIDE) != 0) begin : g_param_check
        $error("window_streamer: illegal parameter combination");
    end

    localparam logic [CW-1:0]  XMAX   = CW'(REG_W - WIN);
    localparam logic [CW-1:0]  YMAX   = CW'(REG_H - WIN);
    localparam logic [CW-1:0]  STEP   = CW'(STRIDE);
    localparam logic [CW-1:0]  WINM1  = CW'(WIN - 1);
    localparam logic [CLW-1:0] COLMAX = CLW'(WPR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CAP,
        S_EMIT,
        S_ADV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [CW-1:0]   rd_row_q, rd_row_d;
    logic [CLW-1:0]  rd_col_q, rd_col_d;
    logic            shift;

    logic            cap_vld_q, cap_vld_d;
    logic [CW-1:0]   cap_slot_q, cap_slot_d;
    logic [CLW-1:0]  cap_col_q, cap_col_d;

    logic [7:0]      lb_q [WIN][REG_W];
    logic [7:0]      lb_d [WIN][REG_W];

    assign rd_en     = (state_q == S_FILL) || (state_q == S_ADV);
    assign win_valid = (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    // busy drops in the done cycle so a consumer sees a clean hand-back.
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rd_row    = rd_row_q;
    assign rd_col    = rd_col_q;
    assign win_x     = x_q;
    assign win_y     = y_q;

    // Sequencer. FILL and ADV share the read walk: both stop after the last
    // word of row y+WIN-1. ADV updates y on entry, so the same test ends it
    // after the STRIDE new rows; rd_row then already points at the next row
    // that a later ADV will need.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        shift    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FILL;
                    x_d      = '0;
                    y_d      = '0;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end
            end
            S_FILL, S_ADV: begin
                if (rd_col_q == COLMAX) begin
                    rd_col_d = '0;
                    rd_row_d = rd_row_q + 1'b1;
                    if (rd_row_q == y_q + WINM1) begin
                        state_d = S_CAP;
                    end
                end else begin
                    rd_col_d = rd_col_q + 1'b1;
                end
            end
            S_CAP: begin
                // last read's data lands in the buffer at the end of this cycle
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (win_ready) begin
                    if (x_q < XMAX) begin
                        x_d = x_q + STEP;
                    end else if (y_q < YMAX) begin
                        state_d = S_ADV;
                        shift   = 1'b1;
                        y_d     = y_q + STEP;
                        x_d     = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture bookkeeping: the slot is computed at request time relative to
    // the current window row, so it is already correct when the data returns.
    always_comb begin
        cap_vld_d  = rd_en;
        cap_slot_d = rd_row_q - y_q;
        cap_col_d  = rd_col_q;
    end

    // Line buffer update. The shift (on entry to ADV) and a capture never
    // coincide because no read is outstanding while a window is presented.
    always_comb begin
        int slot;
        slot = int'(cap_slot_q);
        lb_d = lb_q;
        if (shift) begin
            for (int r = 0; r < WIN; r++) begin
                if (r + STRIDE < WIN) begin
                    lb_d[r] = lb_q[r + STRIDE];
                end
            end
        end
        if (cap_vld_q && slot < WIN) begin
            for (int b = 0; b < BPW; b++) begin
                lb_d[slot][int'(cap_col_q) * BPW + b] = rd_data[b*8 +: 8];
            end
        end
    end

    // Window selection straight from the buffer; stable while x_q is held.
    always_comb begin
        win_data = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_data[(r*WIN + c)*8 +: 8] = lb_q[r][int'(x_q) + c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            cap_col_q  <= '0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < REG_W; c++) begin
                    lb_q[r][c] <= 8'd0;
                end
            end
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            cap_vld_q  <= cap_vld_d;
            cap_slot_q <= cap_slot_d;
            cap_col_q  <= cap_col_d;
            lb_q       <= lb_d;
        end
    end

endmodule

// File: tb/tb_window_streamer.sv
// -----------------------------------------------------------------------------
// tb_window_streamer
//
// Three window_streamer instances (default geometry, WIN=4/8x8/STRIDE=2, and
// BPW=1 16x16 single window) share one frame memory image. A sweep task picks
// one instance, runs a full sweep with random back-pressure and compares every
// read request and every accepted window against a reference built from plain
// loops over the region geometry.
// -----------------------------------------------------------------------------
module tb_window_streamer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] start_v;
    logic       win_ready;

    // instance A: defaults
    logic          a_busy, a_done, a_rd_en, a_valid;
    logic [6:0]    a_rd_row, a_x, a_y;
    logic [4:0]    a_rd_col;
    logic [31:0]   a_rd_data;
    logic [2047:0] a_data;

    // instance B: WIN=4, 8x8, STRIDE=2
    logic          b_busy, b_done, b_rd_en, b_valid;
    logic [2:0]    b_rd_row, b_x, b_y;
    logic [0:0]    b_rd_col;
    logic [31:0]   b_rd_data;
    logic [127:0]  b_data;

    // instance C: BPW=1, 16x16, WIN=16
    logic          c_busy, c_done, c_rd_en, c_valid;
    logic [3:0]    c_rd_row, c_x, c_y;
    logic [3:0]    c_rd_col;
    logic [7:0]    c_rd_data;
    logic [2047:0] c_data;

    window_streamer u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(a_busy), .done(a_done),
        .rd_en(a_rd_en), .rd_row(a_rd_row), .rd_col(a_rd_col), .rd_data(a_rd_data),
        .win_valid(a_valid), .win_ready(win_ready), .win_data(a_data),
        .win_x(a_x), .win_y(a_y)
    );

    window_streamer #(.WIN(4), .REG_W(8), .REG_H(8), .BPW(4), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(b_busy), .done(b_done),
        .rd_en(b_rd_en), .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_data(b_rd_data),
        .win_valid(b_valid), .win_ready(win_ready), .win_data(b_data),
        .win_x(b_x), .win_y(b_y)
    );

    window_streamer #(.WIN(16), .REG_W(16), .REG_H(16), .BPW(1), .STRIDE(1)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(c_busy), .done(c_done),
        .rd_en(c_rd_en), .rd_row(c_rd_row), .rd_col(c_rd_col), .rd_data(c_rd_data),
        .win_valid(c_valid), .win_ready(win_ready), .win_data(c_data),
        .win_x(c_x), .win_y(c_y)
    );

    // frame memory image, pixel (y,x) at mem[y][x]
    logic [7:0] mem [80][80];

    function automatic logic [31:0] mword(input int row, input int col, input int bpw);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < bpw; b++) begin
            if (row < 80 && col * bpw + b < 80) w[b*8 +: 8] = mem[row][col * bpw + b];
        end
        return w;
    endfunction

    // memory port: data one cycle after the request, junk otherwise
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? mword(int'(a_rd_row), int'(a_rd_col), 4) : $urandom;
        b_rd_data <= b_rd_en ? mword(int'(b_rd_row), int'(b_rd_col), 4) : $urandom;
        c_rd_data <= c_rd_en ? 8'(mword(int'(c_rd_row), int'(c_rd_col), 1)) : 8'($urandom);
    end

    // view of the instance under test
    int            sel = 0;
    logic          m_busy, m_done, m_rd_en, m_valid;
    logic [7:0]    m_row, m_col, m_x, m_y;
    logic [2047:0] m_data;

    always_comb begin
        m_busy = 1'b0; m_done = 1'b0; m_rd_en = 1'b0; m_valid = 1'b0;
        m_row = '0; m_col = '0; m_x = '0; m_y = '0; m_data = '0;
        case (sel)
            0: begin
                m_busy = a_busy; m_done = a_done; m_rd_en = a_rd_en; m_valid = a_valid;
                m_row = 8'(a_rd_row); m_col = 8'(a_rd_col); m_x = 8'(a_x); m_y = 8'(a_y);
                m_data = a_data;
            end
            1: begin
                m_busy = b_busy; m_done = b_done; m_rd_en = b_rd_en; m_valid = b_valid;
                m_row = 8'(b_rd_row); m_col = 8'(b_rd_col); m_x = 8'(b_x); m_y = 8'(b_y);
                m_data = 2048'(b_data);
            end
            default: begin
                m_busy = c_busy; m_done = c_done; m_rd_en = c_rd_en; m_valid = c_valid;
                m_row = 8'(c_rd_row); m_col = 8'(c_rd_col); m_x = 8'(c_x); m_y = 8'(c_y);
                m_data = c_data;
            end
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input bit rnd);
        for (int y = 0; y < 80; y++) begin
            for (int x = 0; x < 80; x++) begin
                mem[y][x] = rnd ? 8'($urandom) : 8'((y * 7 + x * 3) & 8'hFF);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_rd_en", m_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_rd_row", m_row, 0);
        check("rst_rd_col", m_col, 0);
        check("rst_win_x", m_x, 0);
        check("rst_win_y", m_y, 0);
        check("rst_win_data_zero", m_data == '0, 1);
    endtask

    // Start a sweep on instance A, assert reset asynchronously mid-cycle after
    // `at` cycles and check that everything clears at once.
    task automatic reset_mid(input int at, input bit in_emit);
        sel = 0;
        @(negedge clk);
        start_v   = 3'b001;
        win_ready = 1'b1;
        repeat (at) begin
            @(negedge clk);
            start_v = '0;
        end
        if (in_emit) check("pre_rst_valid", m_valid, 1);
        else         check("pre_rst_rd_en", m_rd_en, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", m_busy, 0);
            check("post_rst_valid", m_valid, 0);
        end
        win_ready = 1'b0;
    endtask

    task automatic sweep(input int which, input int pct, input bit poke, input int budget);
        int win, rw, rh, bpw, s, wpr, nx, ny, lat, exp_done;
        int wq_x[$], wq_y[$], rq_r[$], rq_c[$];
        int wi, ri, cyc;
        bit fin, first, pv, pr, rdy;
        logic [2047:0] pd;
        logic [7:0]    px, py;
        logic [127:0]  row_got, row_exp, mask;

        case (which)
            0:       begin win = 16; rw = 80; rh = 80; bpw = 4; s = 1; end
            1:       begin win = 4;  rw = 8;  rh = 8;  bpw = 4; s = 2; end
            default: begin win = 16; rw = 16; rh = 16; bpw = 1; s = 1; end
        endcase
        wpr = rw / bpw;
        nx  = (rw - win) / s + 1;
        ny  = (rh - win) / s + 1;
        for (int y = 0; y < ny; y++) begin
            for (int x = 0; x < nx; x++) begin
                wq_x.push_back(x * s);
                wq_y.push_back(y * s);
            end
        end
        for (int r = 0; r < win; r++) begin
            for (int c = 0; c < wpr; c++) begin
                rq_r.push_back(r);
                rq_c.push_back(c);
            end
        end
        for (int k = 1; k < ny; k++) begin
            for (int r = (k - 1) * s + win; r < k * s + win; r++) begin
                for (int c = 0; c < wpr; c++) begin
                    rq_r.push_back(r);
                    rq_c.push_back(c);
                end
            end
        end
        lat      = win * wpr + 2;
        exp_done = lat + nx * ny + (ny - 1) * (s * wpr + 1);
        mask     = (128'd1 << (win * 8)) - 128'd1;

        wi = 0; ri = 0; cyc = 0; fin = 0; first = 1; pv = 0; pr = 0;
        pd = '0; px = '0; py = '0;
        sel = which;
        @(negedge clk);
        start_v        = '0;
        start_v[which] = 1'b1;
        win_ready      = 1'b0;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start_v = '0;
            if (cyc == 1) check("rd_en_cycle1", m_rd_en, 1);
            if (m_rd_en) begin
                if (ri < rq_r.size()) begin
                    check("rd_row", m_row, rq_r[ri]);
                    check("rd_col", m_col, rq_c[ri]);
                end else begin
                    check("extra_read", ri, rq_r.size());
                end
                ri++;
            end
            if (m_valid && first) begin
                check("first_valid_cycle", cyc, lat);
                first = 0;
            end
            if (pv && !pr) begin
                check("stall_valid_held", m_valid, 1);
                check("stall_x_held", m_x, px);
                check("stall_y_held", m_y, py);
                check("stall_data_held", m_data == pd, 1);
            end
            if (m_done) begin
                check("busy_low_at_done", m_busy, 0);
                check("windows_before_done", wi, nx * ny);
                check("reads_before_done", ri, rq_r.size());
                if (pct == 100) check("done_cycle", cyc, exp_done);
                fin = 1;
            end
            rdy       = ($urandom_range(0, 99) < pct);
            win_ready = rdy;
            if (m_valid && rdy) begin
                if (wi < wq_x.size()) begin
                    check("win_x", m_x, wq_x[wi]);
                    check("win_y", m_y, wq_y[wi]);
                    for (int r = 0; r < win; r++) begin
                        row_got = 128'(m_data >> (r * win * 8)) & mask;
                        row_exp = '0;
                        for (int c = 0; c < win; c++) begin
                            row_exp[c*8 +: 8] = mem[wq_y[wi] + r][wq_x[wi] + c];
                        end
                        check("win_row", row_got, row_exp);
                    end
                end else begin
                    check("extra_window", wi, wq_x.size());
                end
                wi++;
            end
            // stray starts: during FILL, during EMIT/ADV, and on the done cycle
            if (poke && (m_done || cyc == 3 || (cyc % 5) == 0)) start_v[which] = 1'b1;
            pv = m_valid; pr = rdy; pd = m_data; px = m_x; py = m_y;
        end
        check("sweep_finished", fin, 1);
        repeat (3) begin
            @(negedge clk);
            start_v = '0;
            check("idle_busy", m_busy, 0);
            check("idle_done", m_done, 0);
        end
        win_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start_v   = '0;
        win_ready = 1'b0;
        fill_mem(0);
        #2 rst = 1'b1;
        #2;
        sel = 0;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", m_busy, 0);

        reset_mid(100, 1'b0);
        reset_mid(350, 1'b1);

        sweep(0, 100, 1'b0, 20000);
        sweep(0, 30, 1'b0, 40000);

        fill_mem(1);
        sweep(1, 100, 1'b1, 2000);
        sweep(1, 100, 1'b0, 2000);
        sweep(1, 40, 1'b0, 2000);

        sweep(2, 100, 1'b0, 2000);
        sweep(2, 30, 1'b0, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
